// File: rtl/grad_square.sv
// grad_square: unsigned squares of a signed Sobel gradient pair (gx^2, gy^2) by iterative shift-add.
// Latency: out_valid rises IN_W edges after the accepting edge; one result per IN_W+2 edges back-to-back.
// Backpressure: result held in HOLD until out_ready; in_ready is low from acceptance until the result is consumed.
module grad_square #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] gx,
  input  logic signed [IN_W-1:0] gy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       sqrx,
  output logic [OUT_W-1:0]       sqry,
  output logic                   busy
);

  // Step counter only needs to reach IN_W-1.
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Per-lane shift-add operands: multiplicand grows left, multiplier drains right.
  logic [OUT_W-1:0] mcand_x_q, mcand_y_q;
  logic [IN_W-1:0]  mplr_x_q,  mplr_y_q;
  logic [OUT_W-1:0] acc_x_q,   acc_y_q;
  logic [OUT_W-1:0] sqrx_q,    sqry_q;
  logic             out_valid_q;

  logic [IN_W-1:0]  abs_x_d,   abs_y_d;
  logic [OUT_W-1:0] acc_x_d,   acc_y_d;

  // Magnitudes as IN_W-bit unsigned: the most negative code negates to itself,
  // whose unsigned reading is exactly 2^(IN_W-1).
  always_comb begin
    abs_x_d = gx[IN_W-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_y_d = gy[IN_W-1] ? $unsigned(-gy) : $unsigned(gy);
  end

  // Accumulator value after the current step; used both for the step and the final load.
  always_comb begin
    acc_x_d = acc_x_q + (mplr_x_q[0] ? mcand_x_q : '0);
    acc_y_d = acc_y_q + (mplr_y_q[0] ? mcand_y_q : '0);
  end

  // Control FSM plus datapath registers; every output is registered or decoded from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_x_q   <= '0;
      mcand_y_q   <= '0;
      mplr_x_q    <= '0;
      mplr_y_q    <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      sqrx_q      <= '0;
      sqry_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_x_q <= {{(OUT_W-IN_W){1'b0}}, abs_x_d};
            mcand_y_q <= {{(OUT_W-IN_W){1'b0}}, abs_y_d};
            mplr_x_q  <= abs_x_d;
            mplr_y_q  <= abs_y_d;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            cnt_q     <= '0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_x_q   <= acc_x_d;
          acc_y_q   <= acc_y_d;
          mcand_x_q <= mcand_x_q << 1;
          mcand_y_q <= mcand_y_q << 1;
          mplr_x_q  <= mplr_x_q >> 1;
          mplr_y_q  <= mplr_y_q >> 1;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            // Last multiplier bit: publish the sums including this step.
            sqrx_q      <= acc_x_d;
            sqry_q      <= acc_y_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC) || (state_q == HOLD);
  assign out_valid = out_valid_q;
  assign sqrx      = sqrx_q;
  assign sqry      = sqry_q;

endmodule
